// File: rtl/fetch_stage_pkg.sv
// Shared fetch constants and the queue entry layout.
//   WORD_SIZE        - instruction / address width
//   RESET_PC_DEFAULT - default PC after reset
//   FETCH_Q_DEPTH    - default output queue depth
//   MISS_MAX         - saturation value of the miss counter
//   fq_entry_t       - {pc, inst} queue entry (64 bits)
package fetch_stage_pkg;
    localparam int          WORD_SIZE        = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          FETCH_Q_DEPTH    = 2;
    localparam logic [15:0] MISS_MAX         = 16'hFFFF;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] inst;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} pairs for decode.
//   enq/enq_data - push an entry
//   deq          - pop the head
//   flush        - empty the queue (wins over enq/deq)
//   count        - current occupancy
//   head_data    - head entry (stale/zero when empty)
//   empty/full   - occupancy flags
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = FETCH_Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq,
    input  fq_entry_t                enq_data,
    input  logic                     deq,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fq_entry_t                head_data,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [AW:0]     cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (enq) begin
                mem_q[wr_q] <= enq_data;
                wr_q        <= wr_q + AW'(1);
            end
            if (deq) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end

    assign count     = cnt_q;
    assign head_data = mem_q[rd_q];
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (AW+1)'(DEPTH));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage in front of a 1-cycle-latency instruction cache.
//   clk, rst_n         - clock, async active-low reset
//   ic_addr            - fetch address (the PC register)
//   ic_hit, ic_inst    - cache hit (same cycle), data (next cycle)
//   redirect_valid/pc  - flush and restart at a new word-aligned PC
//   if_valid/ready     - decode handshake; if_inst/if_pc carry the head
//   miss_cycles        - saturating count of issue attempts that missed
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          Q_DEPTH  = FETCH_Q_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ic_addr,
    input  logic        ic_hit,
    input  logic [31:0] ic_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [15:0] miss_cycles
);
    localparam int CW = $clog2(Q_DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [15:0]   miss_q, miss_d;

    logic [CW-1:0] q_count;
    fq_entry_t     q_head, q_in;
    logic          q_empty, q_full, q_enq, q_deq;
    logic          deq, issue;
    logic [CW:0]   occ;

    assign deq = if_valid & if_ready;

    // Credit counts the in-flight word too, so a returning hit always has a slot.
    assign occ   = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(deq);
    assign issue = ~redirect_valid & (occ < (CW+1)'(Q_DEPTH));

    assign q_enq = inflight_q & ~redirect_valid;
    assign q_deq = deq & ~redirect_valid;
    assign q_in  = '{pc: inflight_pc_q, inst: ic_inst};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        miss_d        = miss_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issue && ic_hit) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd4;
        end else if (issue && miss_q != MISS_MAX) begin
            // Cache refills on this edge; the next cycle simply retries.
            miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            miss_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            miss_q        <= miss_d;
        end
    end

    fetch_queue #(.DEPTH(Q_DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq       (q_enq),
        .enq_data  (q_in),
        .deq       (q_deq),
        .flush     (redirect_valid),
        .count     (q_count),
        .head_data (q_head),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign ic_addr     = pc_q;
    assign if_valid    = ~q_empty;
    assign if_inst     = q_head.inst;
    assign if_pc       = q_head.pc;
    assign miss_cycles = miss_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(q_enq && q_full && !q_deq));
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction cache. It owns the program counter and presents one word address per cycle to the cache. It tracks the one-cycle cache read latency and queues returned instructions in a small FIFO. The FIFO delivers instructions with their PCs to decode over a valid/ready handshake and handles branch redirects and cache-miss retries.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- Q_DEPTH, 2, output queue entries (power of two, ≥2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ic_addr  out  32  fetch address to cache; always equals the PC register.
- ic_hit  in  1  cache hit for ic_addr, combinational, sampled at rising edge.
- ic_inst  in  32  cache data, valid in the cycle after a sampled hit.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode accepts head.
- if_inst  out  32  head instruction.
- if_pc  out  32  head PC.
- miss_cycles  out  16  saturating count of cycles with an issue attempt and ic_hit=0.

## Operation
- State: pc (32), inflight (1), inflight_pc (32), queue (Q_DEPTH × {pc, inst}), count, miss_cycles.
- deq = if_valid & if_ready.
- Issue condition: issue = ~redirect_valid & (count + inflight − deq < Q_DEPTH).
- Issue with ic_hit=1:
  - inflight←1, inflight_pc←pc, pc←pc+4.
  - 32-bit wraparound: 32'hFFFF_FFFC+4 = 0.
- Issue with ic_hit=0:
  - pc holds, inflight←0, miss_cycles increments.
  - miss_cycles saturates at 16'hFFFF.
  - The cache refills on that edge, so the retry next cycle is expected to hit; there is no retry limit.
- No issue: pc holds; inflight←0 unless a hit was issued.
- Capture: when inflight=1 and no redirect, {inflight_pc, ic_inst} is enqueued at the edge.
- Dequeue: on deq, head pops. Enqueue and dequeue in the same cycle keep count unchanged.
- Redirect has priority over everything else in the same cycle:
  - queue emptied, inflight←0, pc←{redirect_pc[31:2],2'b00}.
  - no issue, no capture, dequeue ignored, miss_cycles not incremented.
- Control is implicit in (count, inflight). Effective states:
  - EMPTY: count=0, inflight=0.
  - STREAM: issuing.
  - FULL: no issue credit; waits for deq.
- Queue never overflows; an enqueue into a full queue is an assertion failure.
- if_inst and if_pc are held stable while if_valid=1 and if_ready=0.

## Timing
- Reset (async assert, sync release):
  - pc=RESET_PC, ic_addr=RESET_PC.
  - inflight=0, count=0, if_valid=0, if_inst=0, if_pc=0, miss_cycles=0.
- Reset mid-operation discards queue and in-flight data immediately.
- Latency, hit path: address hits at edge t → ic_inst valid in cycle t+1 → enqueued at edge t+1 → if_valid=1 in cycle t+1 after the edge. This gives 2 edges from issue to visible output with an empty queue.
- Each miss adds exactly 1 cycle per refill.
- Throughput is 1 instruction/cycle with ready held high and all hits.
- Redirect at edge t: first new-target issue in cycle t+1. With a hit, if_valid in cycle t+2.
- if_valid never depends combinationally on if_ready.

## Structure
- WORD_SIZE, RESET_PC default and FETCH_Q_DEPTH go in the shared define file beside the existing cache constants.
- Sub-module fetch_queue:
  - synchronous FIFO, width 64 ({pc, inst}), depth Q_DEPTH.
  - ports: enq, enq_data, deq, flush, count, head_data, empty, full.
  - same clk/rst_n.
- fetch_stage holds the PC, in-flight tracking, issue credit and the miss counter.

## Test plan
- Reset: release rst_n with RESET_PC=0x100 and a cold cache. ic_addr=0x100, miss_cycles=1 after the first edge, and the retry hits. Required: if_valid rises with if_pc=0x100 and if_inst equal to memory[0x100].
- Streaming: if_ready=1 with all hits from 0x0. Required: if_pc 0x0, 0x4, 0x8, … on consecutive cycles with no bubbles.
- Backpressure: if_ready=0 for 5 cycles mid-stream. Required: count reaches Q_DEPTH, pc stops advancing, head stays 0x8 stable, and no instruction is lost or duplicated after release.
- Redirect:
  - redirect_pc=0x203 while the queue is full and a hit is in flight, with if_ready=1 the same cycle.
  - Required: queue empties, no old PC is ever delivered, and next if_pc=0x200.
- Miss accounting: force ic_hit=0 for 3 consecutive cycles at 0x40. Required: pc holds at 0x40, miss_cycles +3, and the instruction is then delivered once.
- Wrap and saturation: fetch from 0xFFFF_FFFC. Required: next PC is 0x0. Preload miss_cycles near 16'hFFFF. Required: it sticks at 16'hFFFF.
